// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight destination registers and stalls decode on RAW hazards.
// Latency: busy_mask/pending_cnt/wb_err update one edge after issue/writeback; issue_ready and stall are combinational.
// Backpressure: issue_ready drops while issue_dest is busy; stall holds decode while a source is pending.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dest,
    input  logic        flush,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        stall,
    output logic [31:0] busy_mask,
    output logic [5:0]  pending_cnt,
    output logic        wb_err
);

    logic [31:0] busy_q, busy_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wb_err_q, wb_err_d;

    logic issue_acc;
    logic wb_clr;
    logic wb_bad;
    logic rs_pend;
    logic rt_pend;

    // A same-cycle writeback is deliberately ignored here so WAW is refused until the bit clears.
    always_comb begin
        issue_ready = (issue_dest == 5'd0) || !busy_q[issue_dest];
    end

    always_comb begin
        issue_acc = issue_valid && issue_ready && !flush && (issue_dest != 5'd0);
        wb_clr    = wb_valid && busy_q[wb_dest];
        wb_bad    = wb_valid && (wb_dest != 5'd0) && !busy_q[wb_dest];
    end

    // Writeback bypass: a source being written back this cycle is no longer a hazard.
    always_comb begin
        rs_pend = (rs_addr != 5'd0) && busy_q[rs_addr] && !(wb_valid && (wb_dest == rs_addr));
        rt_pend = (rt_addr != 5'd0) && busy_q[rt_addr] && !(wb_valid && (wb_dest == rt_addr));
        stall   = rs_pend || rt_pend;
    end

    // Issue needs the bit clear and writeback needs it set, so both never hit the same register.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        wb_err_d = wb_err_q || wb_bad;
        if (flush) begin
            busy_d = 32'd0;
            cnt_d  = 6'd0;
        end else begin
            if (wb_clr) begin
                busy_d[wb_dest] = 1'b0;
            end
            if (issue_acc) begin
                busy_d[issue_dest] = 1'b1;
            end
            cnt_d = cnt_q + {5'd0, issue_acc} - {5'd0, wb_clr};
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 32'd0;
            cnt_q    <= 6'd0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    always_comb begin
        busy_mask   = busy_q;
        pending_cnt = cnt_q;
        wb_err      = wb_err_q;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a register-array reference model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        stall;
    logic [31:0] busy_mask;
    logic [5:0]  pending_cnt;
    logic        wb_err;

    reg_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .flush       (flush),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .stall       (stall),
        .busy_mask   (busy_mask),
        .pending_cnt (pending_cnt),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one flag per register plus the sticky error flag.
    bit m_busy [32];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic bit m_ready(input logic [4:0] d);
        return (d == 0) || !m_busy[d];
    endfunction

    function automatic bit m_pending(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !(wb_valid && wb_dest == r);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic check_model();
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, m_ready(issue_dest)});
        chk("stall", {31'd0, stall}, {31'd0, m_pending(rs_addr) || m_pending(rt_addr)});
        chk("busy_mask", busy_mask, m_mask());
        chk("pending_cnt", {26'd0, pending_cnt}, m_count());
        chk("wb_err", {31'd0, wb_err}, {31'd0, m_err});
    endtask

    task automatic model_update();
        bit rdy;
        bit wb_ok;
        if (!rst_n) begin
            m_clear();
            m_err = 1'b0;
        end else begin
            rdy   = m_ready(issue_dest);
            wb_ok = wb_valid && m_busy[wb_dest];
            if (wb_valid && wb_dest != 0 && !m_busy[wb_dest]) m_err = 1'b1;
            if (flush) begin
                m_clear();
            end else begin
                if (wb_ok) m_busy[wb_dest] = 1'b0;
                if (issue_valid && rdy && issue_dest != 0) m_busy[issue_dest] = 1'b1;
            end
        end
    endtask

    // Inputs are already driven; compare, advance the model, cross one edge.
    task automatic step();
        #1;
        check_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        issue_dest  = 5'd0;
        wb_valid    = 1'b0;
        wb_dest     = 5'd0;
        flush       = 1'b0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd0;
    endtask

    initial begin
        int r;
        idle();
        // Reset with every other control asserted; state must still come up clear.
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        issue_dest  = 5'd4;
        wb_valid    = 1'b1;
        wb_dest     = 5'd9;
        flush       = 1'b1;
        m_clear();
        m_err = 1'b0;
        @(posedge clk);
        #1;
        step();

        idle();
        issue_dest = 5'd31;
        rs_addr    = 5'd31;
        rt_addr    = 5'd5;
        #1;
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_cnt", {26'd0, pending_cnt}, 32'd0);
        chk("rst_err", {31'd0, wb_err}, 32'd0);
        chk("rst_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        step();

        // Issue 5, then a RAW source on 5 stalls.
        idle(); issue_valid = 1'b1; issue_dest = 5'd5;
        step();
        idle(); rs_addr = 5'd5;
        #1;
        chk("i5_busy", busy_mask, 32'h0000_0020);
        chk("i5_cnt", {26'd0, pending_cnt}, 32'd1);
        chk("i5_stall", {31'd0, stall}, 32'd1);
        chk("i5_model_cnt", m_count(), 32'd1);
        step();

        // WAW refused even with same-cycle writeback; bypass removes stall.
        idle(); issue_valid = 1'b1; issue_dest = 5'd5; wb_valid = 1'b1; wb_dest = 5'd5; rs_addr = 5'd5;
        #1;
        chk("waw_ready", {31'd0, issue_ready}, 32'd0);
        chk("bypass_stall", {31'd0, stall}, 32'd0);
        step();
        idle();
        #1;
        chk("waw_busy", busy_mask, 32'h0);
        chk("waw_cnt", {26'd0, pending_cnt}, 32'd0);
        step();

        // Register 0 never becomes busy.
        for (int k = 0; k < 3; k++) begin
            idle(); issue_valid = 1'b1; issue_dest = 5'd0;
            #1;
            chk("r0_ready", {31'd0, issue_ready}, 32'd1);
            step();
        end
        idle();
        #1;
        chk("r0_busy", busy_mask, 32'h0);
        chk("r0_stall", {31'd0, stall}, 32'd0);
        step();

        // Fill every register, then flush against a concurrent issue.
        for (int d = 1; d < 32; d++) begin
            idle(); issue_valid = 1'b1; issue_dest = d[4:0];
            step();
        end
        idle();
        #1;
        chk("full_cnt", {26'd0, pending_cnt}, 32'd31);
        chk("full_busy", busy_mask, 32'hFFFF_FFFE);
        step();
        idle(); flush = 1'b1; issue_valid = 1'b1; issue_dest = 5'd7;
        step();
        idle();
        #1;
        chk("flush_busy", busy_mask, 32'h0);
        chk("flush_cnt", {26'd0, pending_cnt}, 32'd0);
        step();

        // Illegal writeback: sticky across flush, cleared by reset.
        idle(); wb_valid = 1'b1; wb_dest = 5'd9;
        step();
        idle();
        #1;
        chk("err_set", {31'd0, wb_err}, 32'd1);
        chk("err_busy", busy_mask, 32'h0);
        flush = 1'b1;
        step();
        idle();
        #1;
        chk("err_after_flush", {31'd0, wb_err}, 32'd1);
        rst_n = 1'b0;
        step();
        idle();
        #1;
        chk("err_after_rst", {31'd0, wb_err}, 32'd0);
        step();

        // Concurrent issue and writeback on different registers.
        idle(); issue_valid = 1'b1; issue_dest = 5'd12;
        step();
        idle(); issue_valid = 1'b1; issue_dest = 5'd3; wb_valid = 1'b1; wb_dest = 5'd12;
        step();
        idle();
        #1;
        chk("mix_busy", busy_mask, 32'h0000_0008);
        chk("mix_cnt", {26'd0, pending_cnt}, 32'd1);
        step();

        // Randomized traffic, writebacks biased toward registers that are actually busy.
        for (int c = 0; c < 4000; c++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_dest  = 5'($urandom_range(0, 31));
            wb_valid    = ($urandom_range(0, 1) != 0);
            r           = $urandom_range(0, 31);
            if (m_count() > 0 && $urandom_range(0, 7) != 0) begin
                while (!m_busy[r]) r = (r + 1) % 32;
            end
            wb_dest = 5'(r);
            rs_addr = 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 3) == 0) ? wb_dest : 5'($urandom_range(0, 31));
            step();
        end

        idle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
